// File: rtl/processor_pkg.sv
// Shared types and constants for the matrix-vector processor control path.
package processor_pkg;

  localparam int NMAX_DEFAULT  = 16;
  localparam int LANES_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    OP,
    RESULT,
    POP_RES,
    TRANSMIT,
    TX_WAIT,
    DONE
  } MXV_STATE_e;

  // Number of row passes needed to cover n rows with the given lane count.
  function automatic int passes(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/mxv_lane_mask.sv
// Combinational lane-valid generator: lane i is live when its row index
// pass*LANES+i falls inside the latched matrix dimension.
module mxv_lane_mask #(
  parameter int LANES = 4,
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0] pass,
  input  logic [CNT_W-1:0] n,
  output logic [LANES-1:0] lane_mask
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // 32-bit arithmetic so the row index cannot wrap at CNT_W bits.
    assign lane_mask[gi] = (32'(pass) * 32'(LANES) + 32'(gi)) < 32'(n);
  end

endmodule

// File: rtl/mxv_sequencer.sv
// Control sequencer: runs ceil(N/LANES) compute passes over the operand
// stream, then drains N results one at a time through the transmitter.
module mxv_sequencer
  import processor_pkg::*;
#(
  parameter int NMAX  = NMAX_DEFAULT,
  parameter int LANES = LANES_DEFAULT,
  parameter int CNT_W = $clog2(NMAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] N,
  input  logic             fifo_empty,
  input  logic             result_full,
  input  logic             working,
  input  logic             abort,
  output logic             pop,
  output logic             p_enable,
  output logic             p_retro,
  output logic             clr,
  output logic             push,
  output logic [LANES-1:0] lane_mask,
  output logic             pop_result,
  output logic             transmit,
  output logic             busy,
  output logic             done,
  output logic             err
);

  MXV_STATE_e       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             guard_q, guard_d;

  logic [CNT_W-1:0] n_last;
  logic             last_pass;
  logic             start_ok;

  assign n_last    = n_q - CNT_W'(1);
  assign last_pass = (int'(pass_q) == passes(int'(n_q), LANES) - 1);
  assign start_ok  = (N != '0) && (32'(N) <= 32'(NMAX));

  mxv_lane_mask #(
    .LANES(LANES),
    .CNT_W(CNT_W)
  ) u_lane_mask (
    .pass     (pass_q),
    .n        (n_q),
    .lane_mask(lane_mask)
  );

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      col_q   <= '0;
      pass_q  <= '0;
      res_q   <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      col_q   <= col_d;
      pass_q  <= pass_d;
      res_q   <= res_d;
      guard_q <= guard_d;
    end
  end

  // Next-state, counter updates and state-decoded outputs; abort overrides last.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    col_d      = col_q;
    pass_d     = pass_q;
    res_d      = res_q;
    guard_d    = 1'b0;
    pop        = 1'b0;
    p_enable   = 1'b0;
    p_retro    = 1'b0;
    clr        = 1'b0;
    push       = 1'b0;
    pop_result = 1'b0;
    transmit   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!start_ok) begin
            err = 1'b1;
          end else begin
            n_d     = N;
            col_d   = '0;
            pass_d  = '0;
            res_d   = '0;
            clr     = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        pop = !fifo_empty;
        if (!fifo_empty) state_d = OP;
      end
      OP: begin
        p_enable = 1'b1;
        if (col_q == n_last) begin
          col_d   = '0;
          state_d = RESULT;
        end else begin
          col_d   = col_q + CNT_W'(1);
          state_d = LOAD;
        end
      end
      RESULT: begin
        push    = !result_full;
        p_retro = !result_full;
        if (!result_full) begin
          clr = 1'b1;
          if (last_pass) begin
            state_d = POP_RES;
          end else begin
            pass_d  = pass_q + CNT_W'(1);
            state_d = LOAD;
          end
        end
      end
      POP_RES: begin
        pop_result = 1'b1;
        state_d    = TRANSMIT;
      end
      TRANSMIT: begin
        transmit = 1'b1;
        guard_d  = 1'b1;  // transmitter raises working one cycle late
        state_d  = TX_WAIT;
      end
      TX_WAIT: begin
        if (!guard_q && !working) begin
          if (res_q == n_last) begin
            state_d = DONE;
          end else begin
            res_d   = res_q + CNT_W'(1);
            state_d = POP_RES;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      col_d    = col_q;
      pass_d   = pass_q;
      res_d    = res_q;
      guard_d  = 1'b0;
      pop      = 1'b0;
      push     = 1'b0;
      transmit = 1'b0;
      clr      = 1'b1;
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Directed self-checking bench for mxv_sequencer (NMAX=16, LANES=4).
module tb_mxv_sequencer;

  localparam int NMAX  = 16;
  localparam int LANES = 4;
  localparam int CNT_W = 5;

  localparam int C_POP  = 0;
  localparam int C_PEN  = 1;
  localparam int C_PUSH = 2;
  localparam int C_PRS  = 3;
  localparam int C_TX   = 4;
  localparam int C_DONE = 5;
  localparam int C_ERR  = 6;
  localparam int C_BUSY = 7;
  localparam int NCNT   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] N;
  logic             fifo_empty;
  logic             result_full;
  logic             working;
  logic             abort;
  logic             pop, p_enable, p_retro, clr, push;
  logic [LANES-1:0] lane_mask;
  logic             pop_result, transmit, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int cnt [NCNT];
  int base[NCNT];
  logic [LANES-1:0] mask_log[$];
  int mb;
  int wcnt;

  mxv_sequencer #(
    .NMAX (NMAX),
    .LANES(LANES),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N          (N),
    .fifo_empty (fifo_empty),
    .result_full(result_full),
    .working    (working),
    .abort      (abort),
    .pop        (pop),
    .p_enable   (p_enable),
    .p_retro    (p_retro),
    .clr        (clr),
    .push       (push),
    .lane_mask  (lane_mask),
    .pop_result (pop_result),
    .transmit   (transmit),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Transmitter model: working high for the 3 cycles following a transmit.
  always @(posedge clk) begin
    if (!rst)          wcnt <= 0;
    else if (transmit) wcnt <= 3;
    else if (wcnt > 0) wcnt <= wcnt - 1;
  end
  assign working = (wcnt != 0);

  // Event monitor sampled on the falling edge.
  initial for (int k = 0; k < NCNT; k++) cnt[k] = 0;
  always @(negedge clk) begin
    if (pop)        cnt[C_POP]  <= cnt[C_POP] + 1;
    if (p_enable)   cnt[C_PEN]  <= cnt[C_PEN] + 1;
    if (push)       cnt[C_PUSH] <= cnt[C_PUSH] + 1;
    if (pop_result) cnt[C_PRS]  <= cnt[C_PRS] + 1;
    if (transmit)   cnt[C_TX]   <= cnt[C_TX] + 1;
    if (done)       cnt[C_DONE] <= cnt[C_DONE] + 1;
    if (err)        cnt[C_ERR]  <= cnt[C_ERR] + 1;
    if (busy)       cnt[C_BUSY] <= cnt[C_BUSY] + 1;
    if (push)       mask_log.push_back(lane_mask);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  function automatic int d(input int k);
    return cnt[k] - base[k];
  endfunction

  task automatic snap();
    for (int k = 0; k < NCNT; k++) base[k] = cnt[k];
    mb = mask_log.size();
  endtask

  task automatic start_op(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    N     = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (d(C_DONE) == 0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("done_seen", (d(C_DONE) > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b0; start = 1'b0; N = '0;
    fifo_empty = 1'b0; result_full = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({pop, p_enable, p_retro, clr, push, lane_mask, pop_result, transmit, busy, done, err}),
          32'd0);
    rst = 1'b1;

    // 1: N=4, single pass
    snap();
    start_op(4);
    wait_done(300);
    check("t1_pops", d(C_POP), 4);
    check("t1_penable", d(C_PEN), 4);
    check("t1_push", d(C_PUSH), 1);
    check("t1_mask", 32'(mask_log[mb]), 32'hF);
    check("t1_pop_result", d(C_PRS), 4);
    check("t1_transmit", d(C_TX), 4);
    check("t1_done", d(C_DONE), 1);
    check("t1_busy_low", 32'(busy), 0);
    check("t1_busy_cycles", d(C_BUSY), 34);

    // 2: N=5, two passes with partial last pass
    snap();
    start_op(5);
    wait_done(300);
    check("t2_pops", d(C_POP), 10);
    check("t2_push", d(C_PUSH), 2);
    check("t2_mask0", 32'(mask_log[mb]), 32'hF);
    check("t2_mask1", 32'(mask_log[mb+1]), 32'h1);
    check("t2_transmit", d(C_TX), 5);
    check("t2_busy_cycles", d(C_BUSY), 53);

    // 3: rejected starts
    snap();
    start_op(0);
    check("t3_err_n0", d(C_ERR), 1);
    check("t3_busy_n0", 32'(busy), 0);
    start_op(17);
    check("t3_err_n17", d(C_ERR), 2);
    check("t3_busy_total", d(C_BUSY), 0);
    check("t3_pops", d(C_POP), 0);

    // 4: operand FIFO empty for 5 cycles at the second LOAD
    snap();
    start_op(4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fifo_empty = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t4_pops_in_stall", d(C_POP), 1);
    check("t4_pen_in_stall", d(C_PEN), 1);
    fifo_empty = 1'b0;
    wait_done(300);
    check("t4_pops", d(C_POP), 4);
    check("t4_busy_cycles", d(C_BUSY), 39);

    // 5: abort in OP of pass 1, then a fresh N=3 run
    snap();
    start_op(8);
    repeat (18) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    check("t5_in_op", 32'(p_enable), 1);
    check("t5_abort_clr", 32'(clr), 1);
    check("t5_abort_push", 32'(push), 0);
    check("t5_abort_pop", 32'(pop), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_idle_after", 32'(busy), 0);
    repeat (10) @(posedge clk);
    #1;
    check("t5_push", d(C_PUSH), 1);
    check("t5_no_done", d(C_DONE), 0);
    snap();
    start_op(3);
    wait_done(300);
    check("t5_n3_transmit", d(C_TX), 3);
    check("t5_n3_mask", 32'(mask_log[mb]), 32'h7);
    check("t5_n3_busy_cycles", d(C_BUSY), 26);

    // 6: reset pulse during TX_WAIT
    snap();
    start_op(4);
    i = 0;
    while (d(C_TX) == 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    check("t6_tx_seen", d(C_TX), 1);
    #2;
    rst = 1'b0;
    #2;
    check("t6_rst_waits_edge", 32'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    check("t6_outputs_zero",
          32'({pop, p_enable, p_retro, clr, push, lane_mask, pop_result, transmit, busy, done, err}),
          32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_more_tx", d(C_TX), 1);
    check("t6_no_done", d(C_DONE), 0);
    check("t6_pops", d(C_POP), 4);
    check("t6_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mxv_sequencer.md
Name: mxv_sequencer

Overview:
Parametrised control sequencer for the matrix-vector processor datapath. It computes LANES rows in parallel per pass over an N-column operand stream. Each pass pops operands, enables the processing elements and pushes the lane results. After the last pass it drains the N results one at a time through the serial transmitter. Adds stall handshakes, runtime-N range checking, abort, done/err status and lane masking for N not a multiple of LANES.

Parameters:
NMAX, 16, maximum matrix dimension accepted at start
LANES, 4, processing elements operating in parallel; must be 1..NMAX
CNT_W, $clog2(NMAX+1), width of N and the internal counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
N  in  CNT_W  matrix dimension; latched on the accepted start
fifo_empty  in  1  operand FIFO empty; stalls LOAD
result_full  in  1  result FIFO full; stalls RESULT
working  in  1  transmitter busy
abort  in  1  cancel the current operation
pop  out  1  operand FIFO pop, one per column per pass
p_enable  out  1  processing-element accumulate strobe
p_retro  out  1  feed accumulator result back / commit
clr  out  1  clear PE accumulators
push  out  1  write lane results to the result FIFO
lane_mask  out  LANES  valid lanes for the current pass; bit i = row pass*LANES+i < N
pop_result  out  1  pop one result for transmission
transmit  out  1  start-transmit pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, all counters 0, every output 0. Asynchronous reset is forbidden. Reset mid-operation discards everything and applies no further pushes or pops.
- States: IDLE, LOAD, OP, RESULT, POP_RES, TRANSMIT, TX_WAIT, DONE.
- Counters: col (0..N-1), pass (0..ceil(N/LANES)-1), res (0..N-1).
- IDLE, start=1:
  - If N==0 or N>NMAX: err=1 for one cycle; stay in IDLE.
  - Otherwise: latch N, clear the counters, go to LOAD. clr=1 in that same IDLE cycle.
- LOAD: pop = !fifo_empty. If fifo_empty, stay in LOAD. Otherwise go to OP.
- OP: p_enable=1.
  - col==N-1: col<=0, go to RESULT.
  - Otherwise: col++, go to LOAD.
- RESULT: push = !result_full, p_retro = !result_full. If result_full, stay in RESULT. Otherwise:
  - clr=1.
  - Last pass: go to POP_RES.
  - Otherwise: pass++, go to LOAD.
- POP_RES: pop_result=1 for one cycle; go to TRANSMIT.
- TRANSMIT: transmit=1 for one cycle; go to TX_WAIT.
- TX_WAIT:
  - The first cycle after TRANSMIT always stays in TX_WAIT (guard for the transmitter's 1-cycle working latency).
  - After the guard, working==0 exits TX_WAIT: if res==N-1 go to DONE, else res++ and go to POP_RES.
- DONE: done=1 for one cycle; go to IDLE.
- Output decoding: all outputs are decoded from state. The only combinational input terms are pop (fifo_empty) and push/p_retro (result_full). lane_mask is valid in every state and is derived from pass and the latched N.
- Abort: abort=1 in any non-IDLE state moves to IDLE next cycle. pop, push and transmit are forced to 0 in the abort cycle; clr=1 in the abort cycle. Abort takes priority over every other transition. Abort in IDLE is ignored.
- start outside IDLE is ignored; N changes outside IDLE are ignored.
- Latency with no stalls:
  - Compute: ceil(N/LANES)*(2N+1) cycles.
  - Drain: per result, 3 cycles + working time.
  - Done: 1 cycle.

Decomposition:
- processor_pkg gains:
  - the state enum MXV_STATE_e;
  - the NMAX_DEFAULT and LANES_DEFAULT constants;
  - a function computing passes = ceil(N/LANES).
- One sub-module, mxv_lane_mask: a purely combinational generator that turns pass, N and LANES into lane_mask. All counters stay in mxv_sequencer.

Test Plan:
1. LANES=4, N=4, no stalls, working high for 3 cycles after each transmit:
   - 4 pops, 4 p_enable, 1 push with lane_mask=1111.
   - 4 pop_result/transmit pairs, then done pulse; busy falls with done.
2. LANES=4, N=5:
   - 10 pops, 2 pushes; lane_mask=1111, then 0001.
   - 5 transmits, then done.
3. Start with N=0, then with N=17 (NMAX=16):
   - err pulse each time, busy stays 0, no pop.
4. N=4, fifo_empty=1 for 5 cycles at the 2nd LOAD:
   - pop stays 0 throughout, state held in LOAD.
   - Exactly 4 pops total; 5 cycles added to the compute latency.
5. N=8, LANES=4, abort asserted during OP of pass 1:
   - clr=1 in the abort cycle, IDLE next cycle, no push, no done.
   - A new start with N=3 completes with 3 transmits.
6. rst=0 for one clock during TX_WAIT:
   - All outputs 0 on the next edge, state IDLE, no further transmit.
   - rst=0 not aligned to a clk edge has no effect until the edge.
